// File: rtl/light_driver.sv
// Traffic light output stage: registers the controller's light command, inserts an
// all-red clearance when right-of-way changes hands, and generates flash patterns.
module light_driver #(
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned BLINK_HALF   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] light_code,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk_lamp,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [2:0] CodeMainGreen  = 3'd0;
  localparam logic [2:0] CodeMainYellow = 3'd1;
  localparam logic [2:0] CodeSideGreen  = 3'd2;
  localparam logic [2:0] CodeSideYellow = 3'd3;
  localparam logic [2:0] CodeWalk       = 3'd4;
  localparam logic [2:0] CodeAllRed     = 3'd5;
  localparam logic [2:0] CodeWalkFlash  = 3'd6;
  localparam logic [2:0] CodeInvalid    = 3'd7;

  typedef enum logic [1:0] {OwnNone, OwnMain, OwnSide, OwnPed} owner_e;
  typedef enum logic [1:0] {StSteady, StClear, StFault} state_e;

  function automatic owner_e owner_of(input logic [2:0] code);
    case (code)
      CodeMainGreen, CodeMainYellow: owner_of = OwnMain;
      CodeSideGreen, CodeSideYellow: owner_of = OwnSide;
      CodeWalk, CodeWalkFlash:       owner_of = OwnPed;
      default:                       owner_of = OwnNone;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    cur_q, cur_d;
  logic [2:0]    pend_q, pend_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [BW-1:0] blink_q;
  logic          phase_q;

  owner_e own_new, own_cur;
  assign own_new = owner_of(light_code);
  assign own_cur = owner_of(cur_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    clr_d   = clr_q;
    unique case (state_q)
      StSteady: begin
        if (load) begin
          if (light_code == CodeInvalid) begin
            state_d = StFault;
          end else if (light_code != cur_q) begin
            if (own_new == own_cur || own_new == OwnNone || own_cur == OwnNone) begin
              cur_d = light_code;
            end else begin
              pend_d  = light_code;
              cur_d   = CodeAllRed;
              clr_d   = CW'(CLEAR_CYCLES - 1);
              state_d = StClear;
            end
          end
        end
      end
      StClear: begin
        if (load && light_code == CodeInvalid) begin
          state_d = StFault;
        end else begin
          if (load) pend_d = light_code;
          // A Load on the final clearance cycle still wins over the older pending code.
          if (clr_q == '0) begin
            cur_d   = load ? light_code : pend_q;
            state_d = StSteady;
          end else begin
            clr_d = clr_q - CW'(1);
          end
        end
      end
      StFault: ;
      default: state_d = StSteady;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSteady;
      cur_q   <= CodeAllRed;
      pend_q  <= CodeAllRed;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      clr_q   <= clr_d;
    end
  end

  // Free-running flash timebase, independent of commands and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      phase_q <= 1'b1;
    end else if (blink_q == BW'(BLINK_HALF - 1)) begin
      blink_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      blink_q <= blink_q + BW'(1);
    end
  end

  always_comb begin
    main_r    = 1'b0;
    main_y    = 1'b0;
    main_g    = 1'b0;
    side_r    = 1'b0;
    side_y    = 1'b0;
    side_g    = 1'b0;
    walk_lamp = 1'b0;
    busy      = (state_q == StClear);
    fault     = (state_q == StFault);
    if (state_q == StFault) begin
      main_r = phase_q;
      side_r = phase_q;
    end else begin
      main_g    = (cur_q == CodeMainGreen);
      main_y    = (cur_q == CodeMainYellow);
      main_r    = !(main_g || main_y);
      side_g    = (cur_q == CodeSideGreen);
      side_y    = (cur_q == CodeSideYellow);
      side_r    = !(side_g || side_y);
      walk_lamp = (cur_q == CodeWalk) || (cur_q == CodeWalkFlash && phase_q);
    end
  end

endmodule

// File: tb/tb_light_driver.sv
// Bench for light_driver: directed scenarios then random Loads/resets, all compared
// against a behavioural model of the lamp rules.
module tb_light_driver;

  localparam int unsigned CLEAR_CYCLES = 4;
  localparam int unsigned BLINK_HALF   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [2:0] light_code = 3'd0;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, walk_lamp, busy, fault;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 steady, 1 clearing, 2 fault.
  int edges;
  int m_mode;
  int m_cur;
  int m_pend;
  int m_left;

  light_driver #(
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .BLINK_HALF  (BLINK_HALF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .light_code(light_code),
    .main_r    (main_r),
    .main_y    (main_y),
    .main_g    (main_g),
    .side_r    (side_r),
    .side_y    (side_y),
    .side_g    (side_g),
    .walk_lamp (walk_lamp),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  function automatic int owner(input int c);
    if (c == 0 || c == 1) return 1;
    if (c == 2 || c == 3) return 2;
    if (c == 4 || c == 6) return 3;
    return 0;
  endfunction

  function automatic bit phase();
    return ((edges / BLINK_HALF) % 2) == 0;
  endfunction

  task automatic model_reset();
    edges  = 0;
    m_mode = 0;
    m_cur  = 5;
    m_pend = 5;
    m_left = 0;
  endtask

  task automatic model_edge(input bit ld, input int c);
    edges++;
    if (m_mode == 0) begin
      if (ld) begin
        if (c == 7) m_mode = 2;
        else if (c != m_cur) begin
          if (owner(c) == owner(m_cur) || owner(c) == 0 || owner(m_cur) == 0) m_cur = c;
          else begin
            m_pend = c;
            m_cur  = 5;
            m_left = CLEAR_CYCLES;
            m_mode = 1;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (ld && c == 7) m_mode = 2;
      else begin
        if (ld) m_pend = c;
        m_left--;
        if (m_left == 0) begin
          m_cur  = m_pend;
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input string sig, input logic got, input logic exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s.%s got %b expected %b", tag, sig, got, exp);
    end
  endtask

  task automatic check(input string tag);
    logic er_m, ey_m, eg_m, er_s, ey_s, eg_s, ew, eb, ef;
    ey_m = 0; eg_m = 0; ey_s = 0; eg_s = 0; ew = 0;
    eb = (m_mode == 1);
    ef = (m_mode == 2);
    if (ef) begin
      er_m = phase();
      er_s = phase();
    end else begin
      eg_m = (m_cur == 0);
      ey_m = (m_cur == 1);
      er_m = !(m_cur == 0 || m_cur == 1);
      eg_s = (m_cur == 2);
      ey_s = (m_cur == 3);
      er_s = !(m_cur == 2 || m_cur == 3);
      ew   = (m_cur == 4) || (m_cur == 6 && phase());
    end
    cmp(tag, "main_r", main_r, er_m);
    cmp(tag, "main_y", main_y, ey_m);
    cmp(tag, "main_g", main_g, eg_m);
    cmp(tag, "side_r", side_r, er_s);
    cmp(tag, "side_y", side_y, ey_s);
    cmp(tag, "side_g", side_g, eg_s);
    cmp(tag, "walk", walk_lamp, ew);
    cmp(tag, "busy", busy, eb);
    cmp(tag, "fault", fault, ef);
  endtask

  // Called just after a falling edge; inputs change there, outputs sampled at next falling edge.
  task automatic step(input string tag, input bit ld, input int c);
    load       = ld;
    light_code = 3'(c);
    @(posedge clk);
    model_edge(ld, c);
    @(negedge clk);
    load = 1'b0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0);
  endtask

  // Reset asserted and checked between clock edges to exercise the asynchronous path.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("reset");

    step("main_green", 1, 0);
    step("main_yellow", 1, 1);
    step("to_side_green", 1, 2);
    step("clear_c2_walk", 1, 4);
    idle("clear_tail", 4);
    step("walk_flash", 1, 6);
    idle("flash_run", 40);
    step("flash_to_main", 1, 0);
    idle("clear_main", 6);
    step("invalid", 1, 7);
    idle("fault_flash", 20);
    step("fault_ignore", 1, 0);
    idle("fault_hold", 3);
    do_reset("fault_reset");
    idle("post_reset", 2);
    step("main_again", 1, 0);
    step("conflict_side", 1, 2);
    step("clear_mid", 0, 0);
    do_reset("async_mid_clear");
    step("direct_side", 1, 2);
    step("same_code", 1, 2);
    step("to_all_red", 1, 5);
    step("ped_direct", 1, 4);
    step("ped_to_side", 1, 3);
    step("clear_all_red", 1, 5);
    idle("clear_all_red_tail", 4);

    for (int i = 0; i < 600; i++) begin
      int c;
      bit ld;
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_reset");
      end
      c  = $urandom_range(0, 6);
      if ($urandom_range(0, 59) == 0) c = 7;
      ld = ($urandom_range(0, 2) == 0);
      step("random", ld, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_driver.md
# light_driver

Output stage of the traffic light controller, the outbound counterpart to the input synchronizer. The controller FSM presents an encoded light command with a load strobe. This block registers the command and drives the seven lamp outputs. It enforces an all-red clearance interval whenever right-of-way moves between roads or to pedestrians, and generates the flashing patterns for walk-flash and failsafe.

## Interface
- CLEAR_CYCLES, 4: all-red clearance length in clock cycles (≥1)
- BLINK_HALF, 8: half-period of the flash pattern in cycles (≥1)
- clock  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-low reset
- Load  input  1  single-cycle strobe: sample Light_Code
- Light_Code  input  3  0 MAIN_GREEN, 1 MAIN_YELLOW, 2 SIDE_GREEN, 3 SIDE_YELLOW, 4 WALK, 5 ALL_RED, 6 WALK_FLASH, 7 invalid
- Main_R / Main_Y / Main_G  output  1 each  main-road lamps
- Side_R / Side_Y / Side_G  output  1 each  side-road lamps
- Walk_Lamp  output  1  pedestrian walk lamp
- Busy  output  1  high while a clearance interval is running
- Fault  output  1  sticky; invalid code received

## Operation
- State machine: STEADY, CLEAR, FAULT. Registers: current code `cur`, pending code `pend`, clearance counter, blink counter, blink phase.
- Reset state:
  - STEADY with cur = ALL_RED.
  - Main_R = Side_R = 1, all other lamps 0.
  - Busy = 0, Fault = 0, blink phase = 1, counters 0.
- Owner of a code:
  - MAIN for 0 and 1.
  - SIDE for 2 and 3.
  - PED for 4 and 6.
  - NONE for 5.
- Lamp decode for cur:
  - Main road: MAIN_GREEN lights Main_G, MAIN_YELLOW lights Main_Y, all other codes light Main_R.
  - Side road: SIDE_GREEN lights Side_G, SIDE_YELLOW lights Side_Y, all other codes light Side_R.
  - Walk_Lamp: 1 for WALK, blink phase for WALK_FLASH, 0 otherwise.
- STEADY, Load with code c:
  - c == 7: go to FAULT.
  - c == cur: no action.
  - owner(c) == owner(cur), or either owner is NONE: cur ← c directly.
  - Otherwise (conflict): pend ← c, cur ← ALL_RED, counter ← CLEAR_CYCLES−1, go to CLEAR.
- CLEAR:
  - Lamps show ALL_RED and Busy = 1.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: cur ← pend, go to STEADY.
  - Load of a valid code in CLEAR overwrites pend and does not restart the counter; last Load wins. A Load of ALL_RED sets pend = ALL_RED.
  - Load of 7 in CLEAR goes to FAULT immediately.
- FAULT:
  - Main_R = Side_R = blink phase; all other lamps 0.
  - Fault = 1, Busy = 0.
  - All Loads are ignored. Only Reset exits.
- Blink counter:
  - Free-runs from reset, wrapping at BLINK_HALF−1.
  - Phase toggles on each wrap.
  - It is never reset by Load or by state changes.
- Counter widths: $clog2 of the parameter, minimum 1 bit. There is no arithmetic overflow; counters wrap only as described above.

## Timing
- All outputs are registered and change only on a rising clock edge, or asynchronously on Reset assertion.
- Non-conflicting Load at edge n: the new lamps are visible after edge n; latency is 1 cycle.
- Conflicting Load at edge n:
  - All-red and Busy = 1 after edge n.
  - Busy stays high for exactly CLEAR_CYCLES cycles.
  - The target lamps appear after edge n+CLEAR_CYCLES, when Busy falls.
- Invalid Load at edge n: Fault = 1 after edge n, and the lamps enter the flash pattern with the current phase.
- Walk flash: Walk_Lamp is high for BLINK_HALF cycles, then low for BLINK_HALF cycles. Its alignment is fixed by the global blink counter, not by the Load time.
- Reset asserted mid-CLEAR or in FAULT: immediate return to the reset state and values; pend is discarded.
- Load held high on consecutive cycles: each cycle is treated as a separate Load.

## Test plan
- Reset, then Load MAIN_GREEN → one cycle later Main_G = 1, Side_R = 1, Busy = 0. Then Load MAIN_YELLOW → Main_Y = 1 after 1 cycle with no clearance.
- From MAIN_YELLOW, Load SIDE_GREEN with CLEAR_CYCLES = 4 → all-red and Busy = 1 for exactly 4 cycles, then Side_G = 1 and Main_R = 1.
- During that clearance, Load WALK at clearance cycle 2 → Busy still falls after 4 total cycles, then Walk_Lamp = 1 with both reds on.
- Load WALK_FLASH with BLINK_HALF = 8 → Walk_Lamp toggles every 8 cycles, aligned to the free-running phase; Main_R = Side_R = 1 steady.
- Load code 7 from MAIN_GREEN → Fault = 1 next cycle, Main_R/Side_R flashing every 8 cycles, Main_G = 0. A later Load MAIN_GREEN is ignored; Reset low clears Fault and restores steady all-red.
- Assert Reset low asynchronously mid-clearance → outputs go to the reset values without waiting for a clock edge. After release, a Load SIDE_GREEN is applied directly, because the owner was NONE.
